// File: rtl/systolic_ws_drain_if.sv
// Result-side bus between the systolic array south edge, the feeder's start
// pulse and the per-column result-SRAM write ports.
interface systolic_ws_drain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8
);
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);

    logic                       start;
    logic                       busy;
    logic                       done;
    logic [DATA_WIDTH*4-1:0]    col_data_in  [0:COL_NUM-1];
    logic [DATA_WIDTH*4-1:0]    row_data_out [0:COL_NUM-1];
    logic [ROW_ADDR_WIDTH-1:0]  row_wraddr   [0:COL_NUM-1];
    logic                       row_wr_en    [0:COL_NUM-1];

    modport master (
        output start, col_data_in,
        input  busy, done, row_data_out, row_wraddr, row_wr_en
    );

    modport slave (
        input  start, col_data_in,
        output busy, done, row_data_out, row_wraddr, row_wr_en
    );
endinterface

// File: rtl/systolic_ws_drain.sv
// De-skews the per-column partial-sum stream leaving the array south edge and
// turns it into in-order result-SRAM writes, one bank per column.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold, no writes
// S_RUN  | cnt_q counts cycles since start; columns write inside window
module systolic_ws_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8,
    parameter int PIPE_LAT   = 8
) (
    input  logic                clk,
    input  logic                reset,
    systolic_ws_drain_if.slave  bus
);
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM);
    localparam int CNT_WIDTH      = $clog2(PIPE_LAT + ROW_NUM + COL_NUM);
    localparam int K_LAST         = PIPE_LAT + ROW_NUM + COL_NUM - 2;
    localparam int RW             = DATA_WIDTH * 4;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                     state_q;
    logic [CNT_WIDTH-1:0]       cnt_q;
    logic                       done_q;

    logic                       wr_en_q  [0:COL_NUM-1];
    logic                       wr_en_d  [0:COL_NUM-1];
    logic [ROW_ADDR_WIDTH-1:0]  wraddr_q [0:COL_NUM-1];
    logic [ROW_ADDR_WIDTH-1:0]  wraddr_d [0:COL_NUM-1];
    logic [RW-1:0]              data_q   [0:COL_NUM-1];
    logic [RW-1:0]              data_d   [0:COL_NUM-1];

    // Tile sequencer: start launches a run of K_LAST+1 cycles, done marks its end.
    // A start arriving in the done cycle is seen in S_IDLE, so tiles chain back to back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_WIDTH'(K_LAST)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Column c sees row r at its south edge when cnt = PIPE_LAT + c + r; outside
    // that window the input is not a result and data/address hold.
    always_comb begin
        int r;
        r = 0;
        for (int c = 0; c < COL_NUM; c++) begin
            wr_en_d[c]  = 1'b0;
            wraddr_d[c] = wraddr_q[c];
            data_d[c]   = data_q[c];
            r = int'(cnt_q) - PIPE_LAT - c;
            if (state_q == S_RUN && r >= 0 && r < ROW_NUM) begin
                wr_en_d[c]  = 1'b1;
                wraddr_d[c] = ROW_ADDR_WIDTH'(r);
                data_d[c]   = bus.col_data_in[c];
            end
        end
    end

    // Registered SRAM write ports; reset clears them so an abandoned tile writes nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < COL_NUM; c++) begin
                wr_en_q[c]  <= 1'b0;
                wraddr_q[c] <= '0;
                data_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < COL_NUM; c++) begin
                wr_en_q[c]  <= wr_en_d[c];
                wraddr_q[c] <= wraddr_d[c];
                data_q[c]   <= data_d[c];
            end
        end
    end

    assign bus.busy         = (state_q == S_RUN);
    assign bus.done         = done_q;
    assign bus.row_wr_en    = wr_en_q;
    assign bus.row_wraddr   = wraddr_q;
    assign bus.row_data_out = data_q;
endmodule
